imem_loader: RTL and testbench

//  Program loader: the write side of the CPU's instruction memory.
//  - Receives a byte stream over a valid/ready handshake.
//  - Packs bytes big-endian (MIPS order) into 32-bit words.
//  - Writes each word into successive word-aligned IMem addresses.
//  - Holds the single-cycle CPU in reset until the whole image is written.

---
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: write side of the instruction memory.
// Packs a big-endian byte stream into 32-bit words, writes them to
// consecutive word addresses, and keeps the CPU in reset until the image
// has been written completely.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Number of words that fit in the memory; the load stops here.
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     addr_q, addr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            err_q, err_d;
    logic            last_q, last_d;
    logic [ADDR_W:0] count_inc;

    // Next-state, datapath update and output decode for the load FSM.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_d      = err_q;
        last_d     = last_q;
        count_inc  = count_q + 1'b1;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        cpu_hold   = (state_q != S_DONE);
        done       = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                // A fresh load restarts the image from the base address.
                if (start) begin
                    state_d    = S_RECV;
                    byte_idx_d = 2'd0;
                    addr_d     = BASE_ADDR;
                    count_d    = '0;
                    err_d      = 1'b0;
                    last_d     = 1'b0;
                end
            end
            S_RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Byte 0 clears the word so a short final word is zero padded.
                    case (byte_idx_q)
                        2'd0:    wdata_d = {in_data, 24'h0};
                        2'd1:    wdata_d[23:16] = in_data;
                        2'd2:    wdata_d[15:8]  = in_data;
                        default: wdata_d[7:0]   = in_data;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    last_d     = in_last;
                    if (in_last && (byte_idx_q != 2'd3)) begin
                        err_d = 1'b1;
                    end
                    if (in_last || (byte_idx_q == 2'd3)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                imem_we    = 1'b1;
                count_d    = count_inc;
                addr_d     = addr_q + 32'd4;
                byte_idx_d = 2'd0;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (count_inc == CAPACITY) begin
                    // Memory full but the stream did not end: flag overflow.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            wdata_q    <= 32'h0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            last_q     <= last_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and random loads compared against a
// byte-list reference model of the packing, capacity and error rules.
module tb_imem_loader;

    localparam int unsigned AW  = 2;
    localparam int unsigned CAP = 1 << AW;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_last;
    logic [7:0]    in_data;
    logic          in_ready, imem_we, cpu_hold, done, err;
    logic [31:0]   imem_addr, imem_wdata;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stim [32];
    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [31:0] exp_w[$];
    bit          exp_err;
    int          exp_acc;

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen by the memory.
    always @(negedge clk) begin
        if (imem_we) begin
            wq_a.push_back(imem_addr);
            wq_d.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: walk the byte list, emitting words at every 4th byte or last.
    task automatic model(input int n, input bit has_last);
        int k;
        logic [31:0] w;
        bit lst;
        exp_w.delete();
        exp_err = 1'b0;
        exp_acc = 0;
        k = 0;
        w = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (exp_w.size() == CAP) break;
            w = w | (32'(stim[i]) << (24 - 8 * k));
            exp_acc++;
            lst = has_last && (i == n - 1);
            if (lst && k != 3) exp_err = 1'b1;
            k++;
            if (k == 4 || lst) begin
                exp_w.push_back(w);
                w = 32'h0;
                k = 0;
                if (lst) break;
                if (exp_w.size() == CAP) begin
                    exp_err = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer n bytes; a byte not taken within a few cycles is abandoned.
    task automatic send(input int n, input bit has_last, input bit gaps,
                        input int start_at, output int acc);
        int to;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom);
                    in_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = has_last && (i == n - 1);
            start    = (i == start_at);
            to = 0;
            while (!in_ready && to < 8) begin
                @(negedge clk);
                start = 1'b0;
                to++;
            end
            if (in_ready) acc++;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (!done && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_load(input string tag, input int n, input bit has_last,
                            input bit gaps, input int start_at, input bit chk_start);
        int base;
        int acc;
        base = wq_a.size();
        model(n, has_last);
        pulse_start();
        if (chk_start) begin
            chk({tag, "_st_err"},  32'(err), 32'd0);
            chk({tag, "_st_done"}, 32'(done), 32'd0);
            chk({tag, "_st_hold"}, 32'(cpu_hold), 32'd1);
            chk({tag, "_st_cnt"},  32'(word_count), 32'd0);
            chk({tag, "_st_addr"}, imem_addr, BASE);
        end
        send(n, has_last, gaps, start_at, acc);
        wait_done(tag);
        repeat (2) @(negedge clk);
        chk({tag, "_acc"}, acc, exp_acc);
        chk({tag, "_nwr"}, wq_a.size() - base, exp_w.size());
        for (int j = 0; j < exp_w.size(); j++) begin
            if (base + j < wq_a.size()) begin
                chk($sformatf("%s_a%0d", tag, j), wq_a[base + j], BASE + 32'(4 * j));
                chk($sformatf("%s_d%0d", tag, j), wq_d[base + j], exp_w[j]);
            end
        end
        chk({tag, "_err"},   32'(err), 32'(exp_err));
        chk({tag, "_done"},  32'(done), 32'd1);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_rdy"},   32'(in_ready), 32'd0);
        chk({tag, "_cnt"},   32'(word_count), 32'(exp_w.size()));
        chk({tag, "_addr"},  imem_addr, BASE + 32'(4 * exp_w.size()));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},  32'(in_ready), 32'd0);
        chk({tag, "_we"},   32'(imem_we), 32'd0);
        chk({tag, "_addr"}, imem_addr, BASE);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
        chk({tag, "_cnt"},  32'(word_count), 32'd0);
    endtask

    initial begin
        int acc;
        int nb;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("rst");
        chk("rst_wdata", imem_wdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Two full words, gap-free.
        for (int i = 0; i < 8; i++) stim[i] = 8'(i * 8'h11);
        run_load("t1", 8, 1'b1, 1'b0, -1, 1'b0);

        // Truncated final word, then start-in-DONE clears the sticky error.
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
        stim[3] = 8'hDD; stim[4] = 8'hEE; stim[5] = 8'hFF;
        run_load("t2", 6, 1'b1, 1'b0, -1, 1'b1);
        for (int i = 0; i < 8; i++) stim[i] = 8'(i * 8'h11);
        run_load("t2b", 8, 1'b1, 1'b0, -1, 1'b1);

        // Capacity overflow without last, then last exactly on the final word.
        for (int i = 0; i < 20; i++) stim[i] = 8'(8'h40 + i);
        run_load("t3", 20, 1'b0, 1'b0, -1, 1'b0);
        run_load("t3b", 16, 1'b1, 1'b0, -1, 1'b0);
        run_load("t3c", 13, 1'b1, 1'b1, -1, 1'b0);

        // Same image with back-pressure gaps must pack identically.
        for (int i = 0; i < 8; i++) stim[i] = 8'(i * 8'h11);
        run_load("t4", 8, 1'b1, 1'b1, -1, 1'b0);

        // Random images with random gaps.
        for (int r = 0; r < 8; r++) begin
            nb = $urandom_range(1, 20);
            for (int i = 0; i < nb; i++) stim[i] = 8'($urandom);
            run_load($sformatf("rnd%0d", r), nb, 1'b1, 1'b1, -1, 1'b0);
        end

        // Reset in the middle of the second word.
        for (int i = 0; i < 8; i++) stim[i] = 8'(8'h80 + i);
        pulse_start();
        nb = wq_a.size();
        send(6, 1'b0, 1'b0, -1, acc);
        chk("t5_acc", acc, 32'd6);
        chk("t5_nwr_pre", wq_a.size() - nb, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_nwr_post", wq_a.size() - nb, 32'd1);
        chk_idle("t5");
        run_load("t5b", 8, 1'b1, 1'b0, -1, 1'b0);

        // Start pulsed while receiving is ignored.
        for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
        run_load("t6", 12, 1'b1, 1'b1, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
